// File: rtl/double_mem_sequencer_if.sv
// Bundle of request, data-memory and write-back signals around the double-word
// MEM-stage sequencer.
//   slave  : the sequencer (consumes requests and read data, drives memory/WB/stall)
//   master : the pipeline/memory side (drives requests and read data)
interface double_mem_sequencer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned REG_W  = 4
);
  logic              req_valid;
  logic [5:0]        req_op;
  logic [REG_W-1:0]  req_rd;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata_lo;
  logic [DATA_W-1:0] req_wdata_hi;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ren;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic              wb_en;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              stall;
  logic              done;
  logic              exc_odd;

  modport slave (
    input  req_valid, req_op, req_rd, req_addr, req_wdata_lo, req_wdata_hi, mem_rdata,
    output mem_addr, mem_ren, mem_wen, mem_wdata, wb_en, wb_rd, wb_data, stall, done, exc_odd
  );

  modport master (
    output req_valid, req_op, req_rd, req_addr, req_wdata_lo, req_wdata_hi, mem_rdata,
    input  mem_addr, mem_ren, mem_wen, mem_wdata, wb_en, wb_rd, wb_data, stall, done, exc_odd
  );
endinterface

// File: rtl/double_mem_sequencer.sv
// MEM-stage responder for double-word ops (LDW op 8, SDW op 9). An accepted
// request is split into two word accesses, addr then addr+1, over the next two
// cycles. LDW writes back rd and rd+1; SDW stores the lo/hi words.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : synchronous active-high reset
//   bus  : slave side of double_mem_sequencer_if (request in, memory/WB out,
//          stall, done and odd-rd exception pulses)
module double_mem_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned REG_W  = 4
) (
  input logic                  clk,
  input logic                  rst,
  double_mem_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StFirst, StSecond} state_e;

  state_e            state_q, state_d;
  logic              sdw_q;
  logic [REG_W-1:0]  rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_lo_q;
  logic [DATA_W-1:0] wdata_hi_q;

  logic is_dbl;
  logic in_first;
  logic accept;
  logic unused_op_hi;

  // Only the low nibble of the op code selects a double op.
  assign unused_op_hi = ^bus.req_op[5:4];
  assign is_dbl       = (bus.req_op[3:0] == 4'd8) || (bus.req_op[3:0] == 4'd9);
  assign in_first     = (state_q == StFirst);
  assign accept       = bus.req_valid & is_dbl & ~bus.req_rd[0] & ~in_first;
  assign bus.exc_odd  = bus.req_valid & is_dbl &  bus.req_rd[0] & ~in_first;
  assign bus.stall    = accept | in_first;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sdw_q      <= 1'b0;
      rd_q       <= '0;
      addr_q     <= '0;
      wdata_lo_q <= '0;
      wdata_hi_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sdw_q      <= (bus.req_op[3:0] == 4'd9);
        rd_q       <= bus.req_rd;
        addr_q     <= bus.req_addr;
        wdata_lo_q <= bus.req_wdata_lo;
        wdata_hi_q <= bus.req_wdata_hi;
      end
    end
  end

  // Memory/WB/done decode from registered state only; unused outputs held at 0.
  always_comb begin
    state_d       = state_q;
    bus.mem_addr  = '0;
    bus.mem_ren   = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_wdata = '0;
    bus.wb_en     = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    bus.done      = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) state_d = StFirst;
      end
      StFirst: begin
        bus.mem_addr = addr_q;
        if (sdw_q) begin
          bus.mem_wen   = 1'b1;
          bus.mem_wdata = wdata_lo_q;
        end else begin
          bus.mem_ren = 1'b1;
          bus.wb_en   = 1'b1;
          bus.wb_rd   = rd_q;
          bus.wb_data = bus.mem_rdata;
        end
        state_d = StSecond;
      end
      StSecond: begin
        // Wraps to 0 past the top of the address space.
        bus.mem_addr = addr_q + ADDR_W'(1);
        if (sdw_q) begin
          bus.mem_wen   = 1'b1;
          bus.mem_wdata = wdata_hi_q;
        end else begin
          bus.mem_ren = 1'b1;
          bus.wb_en   = 1'b1;
          // rd_q is even, so +1 cannot carry out.
          bus.wb_rd   = rd_q + REG_W'(1);
          bus.wb_data = bus.mem_rdata;
        end
        bus.done = 1'b1;
        // Back-to-back acceptance skips the idle bubble.
        state_d  = accept ? StFirst : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_double_mem_sequencer.sv
module tb_double_mem_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  double_mem_sequencer_if bus ();

  double_mem_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Data memory seen by the DUT (low 8 address bits) and the reference copy.
  logic [31:0] dmem    [256];
  logic [31:0] ref_mem [256];
  assign bus.mem_rdata = dmem[bus.mem_addr[7:0]];

  typedef struct {
    bit          sdw;
    logic [31:0] addr;
    logic [3:0]  rd;
    logic [31:0] wdata;
    bit          last;
  } acc_t;

  acc_t pending[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the transaction model, then
  // advance the model and the memory across the rising edge.
  task automatic step(input logic v, input logic [5:0] op, input logic [3:0] rd,
                      input logic [31:0] addr, input logic [31:0] lo, input logic [31:0] hi,
                      input logic r);
    acc_t        cur;
    bit          have, busy_first, dbl, acc, exc;
    logic        d_wen;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    @(negedge clk);
    bus.req_valid    = v;
    bus.req_op       = op;
    bus.req_rd       = rd;
    bus.req_addr     = addr;
    bus.req_wdata_lo = lo;
    bus.req_wdata_hi = hi;
    rst              = r;
    #1;
    have = (pending.size() > 0);
    if (have) cur = pending[0];
    busy_first = have && !cur.last;
    dbl = (op[3:0] == 4'd8) || (op[3:0] == 4'd9);
    acc = v && dbl && !rd[0] && !busy_first;
    exc = v && dbl &&  rd[0] && !busy_first;
    if (chk_en) begin
      check_eq("stall",     32'(bus.stall),   32'(acc || busy_first));
      check_eq("exc_odd",   32'(bus.exc_odd), 32'(exc));
      check_eq("done",      32'(bus.done),    32'(have && cur.last));
      check_eq("mem_ren",   32'(bus.mem_ren), 32'(have && !cur.sdw));
      check_eq("mem_wen",   32'(bus.mem_wen), 32'(have && cur.sdw));
      check_eq("mem_addr",  bus.mem_addr,     have ? cur.addr : 32'h0);
      check_eq("mem_wdata", bus.mem_wdata,    (have && cur.sdw) ? cur.wdata : 32'h0);
      check_eq("wb_en",     32'(bus.wb_en),   32'(have && !cur.sdw));
      check_eq("wb_rd",     32'(bus.wb_rd),   (have && !cur.sdw) ? 32'(cur.rd) : 32'h0);
      check_eq("wb_data",   bus.wb_data,
               (have && !cur.sdw) ? ref_mem[cur.addr[7:0]] : 32'h0);
    end
    if (have && cur.sdw) ref_mem[cur.addr[7:0]] = cur.wdata;
    if (have) void'(pending.pop_front());
    if (r) begin
      pending.delete();
    end else if (acc) begin
      pending.push_back('{sdw: (op[3:0] == 4'd9), addr: addr, rd: rd, wdata: lo, last: 1'b0});
      pending.push_back('{sdw: (op[3:0] == 4'd9), addr: addr + 32'd1, rd: rd + 4'd1,
                          wdata: hi, last: 1'b1});
    end
    d_wen   = bus.mem_wen;
    d_addr  = bus.mem_addr[7:0];
    d_wdata = bus.mem_wdata;
    @(posedge clk);
    if (d_wen === 1'b1) dmem[d_addr] = d_wdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 6'd0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  lo4;
    for (int i = 0; i < 256; i++) begin
      dmem[i]    = $urandom;
      ref_mem[i] = dmem[i];
    end
    dmem[8'h10] = 32'hAAAA0001; ref_mem[8'h10] = 32'hAAAA0001;
    dmem[8'h11] = 32'hBBBB0002; ref_mem[8'h11] = 32'hBBBB0002;

    step(1'b0, 6'd0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    chk_en = 1'b1;
    step(1'b0, 6'd0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    idle(2);

    // LDW pair read
    step(1'b1, 6'd8, 4'd4, 32'h10, 32'd0, 32'd0, 1'b0);
    idle(3);
    // SDW pair write
    step(1'b1, 6'd9, 4'd2, 32'h20, 32'h11, 32'h22, 1'b0);
    idle(3);
    check_eq("sdw_lo_mem", dmem[8'h20], 32'h11);
    check_eq("sdw_hi_mem", dmem[8'h21], 32'h22);
    // odd rd exception
    step(1'b1, 6'd8, 4'd3, 32'h30, 32'd0, 32'd0, 1'b0);
    idle(1);
    // back-to-back: SDW presented during LDW's SECOND cycle
    step(1'b1, 6'd8, 4'd0, 32'h40, 32'd0, 32'd0, 1'b0);
    step(1'b0, 6'd0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 6'd9, 4'd6, 32'h50, 32'h55, 32'h66, 1'b0);
    idle(3);
    // reset during SDW FIRST aborts the second write
    a = dmem[8'h61];
    step(1'b1, 6'd9, 4'd2, 32'h60, 32'h77, 32'h88, 1'b0);
    step(1'b0, 6'd0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    idle(3);
    check_eq("rst_abort_mem", dmem[8'h61], a);
    // address wrap and non-double op
    step(1'b1, 6'd8, 4'd8, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0);
    idle(2);
    step(1'b1, 6'd1, 4'd2, 32'h10, 32'd0, 32'd0, 1'b0);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'hFFFF_FFFF;
        1:       a = 32'hFFFF_FFFE;
        2:       a = $urandom_range(0, 63);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 2))
        0:       lo4 = 4'd8;
        1:       lo4 = 4'd9;
        default: lo4 = 4'($urandom);
      endcase
      step(($urandom_range(0, 9) < 6), {2'($urandom), lo4}, 4'($urandom), a,
           $urandom, $urandom, ($urandom_range(0, 49) == 0));
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
